// File: rtl/ann_pkg.sv
// Shared ANN datapath definitions: sizes, gradient FSM states, saturation helper.
package ann_pkg;

  localparam int unsigned NEURON_SIZE = 4;
  localparam int unsigned WORD_SIZE   = 16;
  localparam int unsigned PROD_SIZE   = 2 * WORD_SIZE;

  // Weight-step magnitude limit, only used when ANN_GRAD_CLIP_EN is defined.
  localparam int CLIP_MAX = 256;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } grad_state_t;

  localparam logic signed [WORD_SIZE-1:0] WORD_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [WORD_SIZE-1:0] WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic signed [PROD_SIZE:0]   WORD_MAX_EXT = (PROD_SIZE+1)'(WORD_MAX);
  localparam logic signed [PROD_SIZE:0]   WORD_MIN_EXT = (PROD_SIZE+1)'(WORD_MIN);

  // Clamp a PROD_SIZE+1 signed value into the signed WORD_SIZE range.
  function automatic logic signed [WORD_SIZE-1:0] sat_word(input logic signed [PROD_SIZE:0] v);
    if (v > WORD_MAX_EXT) begin
      return WORD_MAX;
    end else if (v < WORD_MIN_EXT) begin
      return WORD_MIN;
    end else begin
      return v[WORD_SIZE-1:0];
    end
  endfunction

endpackage

// File: rtl/neuron_grad_update_grad_step.sv
// grad_step: combinational per-element weight update and error back-propagation.
// Optional step clamp to +/-CLIP_MAX is enabled by defining ANN_GRAD_CLIP_EN.
module grad_step
  import ann_pkg::*;
#(
  parameter int unsigned LR_SHIFT = 3
) (
  input  logic [WORD_SIZE-1:0] delta_i,
  input  logic [WORD_SIZE-1:0] x_i,
  input  logic [WORD_SIZE-1:0] w_i,
  output logic [WORD_SIZE-1:0] w_new_o,
  output logic [WORD_SIZE-1:0] err_o
);

`ifdef ANN_GRAD_CLIP_EN
  localparam logic signed [PROD_SIZE-1:0] CLIP_HI = PROD_SIZE'(CLIP_MAX);
  localparam logic signed [PROD_SIZE-1:0] CLIP_LO = -CLIP_HI;
`endif

  logic signed [PROD_SIZE-1:0] grad;
  logic signed [PROD_SIZE-1:0] step;
  logic signed [PROD_SIZE-1:0] step_lim;
  logic signed [PROD_SIZE-1:0] err_prod;
  logic signed [PROD_SIZE:0]   w_diff;

  // Gradient, scaled step, optional clamp, then saturated subtraction and error product.
  always_comb begin
    grad = $signed(delta_i) * $signed(x_i);
    step = grad >>> LR_SHIFT;
`ifdef ANN_GRAD_CLIP_EN
    if (step > CLIP_HI) begin
      step_lim = CLIP_HI;
    end else if (step < CLIP_LO) begin
      step_lim = CLIP_LO;
    end else begin
      step_lim = step;
    end
`else
    step_lim = step;
`endif
    w_diff   = (PROD_SIZE+1)'($signed(w_i)) - (PROD_SIZE+1)'(step_lim);
    err_prod = $signed(delta_i) * $signed(w_i);
    w_new_o  = sat_word(w_diff);
    err_o    = sat_word((PROD_SIZE+1)'(err_prod));
  end

endmodule

// File: rtl/neuron_grad_update.sv
// neuron_grad_update: sequential backward pass for one neuron, one element per cycle.
// Optional feature macro: ANN_GRAD_CLIP_EN (clamps the weight step inside grad_step).
module neuron_grad_update
  import ann_pkg::*;
#(
  parameter int unsigned LR_SHIFT = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  input  logic [WORD_SIZE-1:0]                  delta_i,
  input  logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] x_i,
  input  logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] weights_i,
  output logic                                  ready_o,
  output logic                                  done_o,
  output logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] weights_o,
  output logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] err_o
);

  localparam int unsigned IDX_W = (NEURON_SIZE > 1) ? $clog2(NEURON_SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NEURON_SIZE - 1);

  grad_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WORD_SIZE-1:0] delta_q, delta_d;
  logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] x_q, x_d;
  logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] w_q, w_d;
  logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] weights_q, weights_d;
  logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] err_q, err_d;

  logic [WORD_SIZE-1:0] w_new;
  logic [WORD_SIZE-1:0] err_new;

  grad_step #(
    .LR_SHIFT(LR_SHIFT)
  ) u_grad_step (
    .delta_i (delta_q),
    .x_i     (x_q[idx_q]),
    .w_i     (w_q[idx_q]),
    .w_new_o (w_new),
    .err_o   (err_new)
  );

  // Next-state, operand latch on accept, and per-element result write-back.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    delta_d   = delta_q;
    x_d       = x_q;
    w_d       = w_q;
    weights_d = weights_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          delta_d = delta_i;
          x_d     = x_i;
          w_d     = weights_i;
          idx_d   = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        weights_d[idx_q] = w_new;
        err_d[idx_q]     = err_new;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and output registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      delta_q   <= '0;
      x_q       <= '0;
      w_q       <= '0;
      weights_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      delta_q   <= delta_d;
      x_q       <= x_d;
      w_q       <= w_d;
      weights_q <= weights_d;
      err_q     <= err_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign done_o    = (state_q == DONE);
  assign weights_o = weights_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_neuron_grad_update.sv
// Self-checking bench for neuron_grad_update: vector table plus scoreboard queue.
module tb_neuron_grad_update;
  import ann_pkg::*;

  typedef logic [NEURON_SIZE-1:0][WORD_SIZE-1:0] word_vec_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] delta;
    word_vec_t            x;
    word_vec_t            w;
    word_vec_t            exp_w;
    word_vec_t            exp_err;
  } vec_t;

  logic      clk_i;
  logic      rst_i;
  logic      start_i;
  logic [WORD_SIZE-1:0] delta_i;
  word_vec_t x_i;
  word_vec_t weights_i;
  logic      ready_o;
  logic      done_o;
  word_vec_t weights_o;
  word_vec_t err_o;

  neuron_grad_update #(
    .LR_SHIFT(3)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .delta_i   (delta_i),
    .x_i       (x_i),
    .weights_i (weights_i),
    .ready_o   (ready_o),
    .done_o    (done_o),
    .weights_o (weights_o),
    .err_o     (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t sb_q[$];
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic word_vec_t pack4(input int a0, input int a1, input int a2, input int a3);
    word_vec_t r;
    r[0] = WORD_SIZE'(a0);
    r[1] = WORD_SIZE'(a1);
    r[2] = WORD_SIZE'(a2);
    r[3] = WORD_SIZE'(a3);
    return r;
  endfunction

  function automatic longint sat_ref(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference model: 64-bit integer arithmetic, floor shift, optional clamp, saturate.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    longint g, step, d;
    r = v;
    d = longint'($signed(v.delta));
    for (int i = 0; i < NEURON_SIZE; i++) begin
      g    = d * longint'($signed(v.x[i]));
      step = g >>> 3;
`ifdef ANN_GRAD_CLIP_EN
      if (step > 256) step = 256;
      if (step < -256) step = -256;
`endif
      r.exp_w[i]   = WORD_SIZE'(sat_ref(longint'($signed(v.w[i])) - step));
      r.exp_err[i] = WORD_SIZE'(sat_ref(d * longint'($signed(v.w[i]))));
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v = '0;
    v.delta = WORD_SIZE'($urandom);
    for (int i = 0; i < NEURON_SIZE; i++) begin
      v.x[i] = WORD_SIZE'($urandom);
      v.w[i] = WORD_SIZE'($urandom);
    end
    return v;
  endfunction

  task automatic scramble_inputs();
    delta_i   = WORD_SIZE'($urandom);
    x_i       = word_vec_t'({$urandom, $urandom});
    weights_i = word_vec_t'({$urandom, $urandom});
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    for (int i = 0; i < NEURON_SIZE; i++) begin
      check($sformatf("%s_w%0d", tag, i), int'($signed(weights_o[i])), int'($signed(e.exp_w[i])));
      check($sformatf("%s_err%0d", tag, i), int'($signed(err_o[i])), int'($signed(e.exp_err[i])));
    end
  endtask

  // Called at a negedge; drives one request, scores the result at done_o.
  task automatic run_op(input vec_t v, input string tag, input bit hold);
    int   lat;
    bit   seen;
    vec_t e;
    lat = 0;
    while (!ready_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    check({tag, "_ready_before"}, int'(ready_o), 1);
    start_i   = 1'b1;
    delta_i   = v.delta;
    x_i       = v.x;
    weights_i = v.w;
    sb_q.push_back(v);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (done_o) seen = 1'b1;
      else begin
        if (!hold) start_i = 1'b0;
        scramble_inputs();
      end
    end
    check({tag, "_latency"}, lat, 5);
    if (seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_outputs(tag, e);
    end else begin
      check({tag, "_done_seen"}, int'(seen), 1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check({tag, "_ready_after"}, int'(ready_o), 1);
    check({tag, "_done_pulse"}, int'(done_o), 0);
    if (hold) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk_i);
        #1;
        check($sformatf("%s_no_second_done%0d", tag, c), int'(done_o), 0);
      end
      if (seen) check_outputs({tag, "_held"}, e);
    end
    @(negedge clk_i);
  endtask

  initial begin
    tbl[0] = '{delta: 16'd8, x: pack4(1, 2, 3, 4), w: pack4(100, 100, 100, 100),
               exp_w: pack4(99, 98, 97, 96), exp_err: pack4(800, 800, 800, 800)};
    tbl[1] = '{delta: WORD_SIZE'(-1), x: pack4(1, 1, 1, 1), w: pack4(0, 0, 0, 0),
               exp_w: pack4(1, 1, 1, 1), exp_err: pack4(0, 0, 0, 0)};
    tbl[2] = '{delta: 16'd32767, x: pack4(32767, 0, 0, 0), w: pack4(-32760, 5, 5, 5),
               exp_w: pack4(-32768, 5, 5, 5), exp_err: pack4(-32768, 32767, 32767, 32767)};
    tbl[3] = '{delta: 16'd2, x: pack4(0, 0, 0, 0), w: pack4(32767, 0, 0, 0),
               exp_w: pack4(32767, 0, 0, 0), exp_err: pack4(32767, 0, 0, 0)};
    tbl[4] = '{delta: 16'd0, x: pack4(1234, -5, 77, 32767), w: pack4(10, -20, 30, -40),
               exp_w: pack4(10, -20, 30, -40), exp_err: pack4(0, 0, 0, 0)};
    tbl[5] = '{delta: WORD_SIZE'(-32768), x: pack4(-32768, -32768, -32768, -32768),
               w: pack4(-32768, 0, 32767, 1),
               exp_w: pack4(-32768, -32768, -32768, -32768),
               exp_err: pack4(32767, 0, -32768, -32768)};
`ifdef ANN_GRAD_CLIP_EN
    tbl[6] = '{delta: 16'd100, x: pack4(1000, 1000, 1000, 1000), w: pack4(0, 0, 0, 0),
               exp_w: pack4(-256, -256, -256, -256), exp_err: pack4(0, 0, 0, 0)};
`else
    tbl[6] = '{delta: 16'd100, x: pack4(1000, 1000, 1000, 1000), w: pack4(0, 0, 0, 0),
               exp_w: pack4(-12500, -12500, -12500, -12500), exp_err: pack4(0, 0, 0, 0)};
`endif
    tbl[7] = '{delta: 16'd3, x: pack4(5, -5, 7, -7), w: pack4(0, 0, 0, 0),
               exp_w: pack4(-1, 2, -2, 3), exp_err: pack4(0, 0, 0, 0)};

    rst_i     = 1'b1;
    start_i   = 1'b0;
    delta_i   = '0;
    x_i       = '0;
    weights_i = '0;
    #1;
    check("reset_ready", int'(ready_o), 1);
    check("reset_done", int'(done_o), 0);
    for (int i = 0; i < NEURON_SIZE; i++) begin
      check($sformatf("reset_w%0d", i), int'($signed(weights_o[i])), 0);
      check($sformatf("reset_err%0d", i), int'($signed(err_o[i])), 0);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int t = 0; t < 8; t++) begin
      run_op(tbl[t], $sformatf("vec%0d", t), 1'b0);
    end

    for (int r = 0; r < 4; r++) begin
      run_op(model(rand_vec()), $sformatf("rand%0d", r), 1'b0);
    end

    // start_i held high with changing inputs across the whole operation.
    run_op(tbl[0], "hold", 1'b1);

    // Abort during UPDATE idx=2: outputs clear at once, no done_o afterwards.
    start_i   = 1'b1;
    delta_i   = tbl[0].delta;
    x_i       = tbl[0].x;
    weights_i = tbl[0].w;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    check("abort_mid_w0", int'($signed(weights_o[0])), 99);
    rst_i = 1'b1;
    #1;
    check("abort_ready", int'(ready_o), 1);
    check("abort_done", int'(done_o), 0);
    for (int i = 0; i < NEURON_SIZE; i++) begin
      check($sformatf("abort_w%0d", i), int'($signed(weights_o[i])), 0);
      check($sformatf("abort_err%0d", i), int'($signed(err_o[i])), 0);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i);
      #1;
      check($sformatf("abort_no_done%0d", c), int'(done_o), 0);
    end
    @(negedge clk_i);
    run_op(tbl[0], "post_abort", 1'b0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
